data_mem_hs: RTL and testbench
==============================

// Module: data_mem_hs
// PURPOSE
//  Byte-addressed, big-endian data memory for the MIPS32 core. Single request
//  channel (valid/ready) plus fixed-latency response pipe; sub-word and
//  sign-extended access, fault reporting, and hardware clear FSM.
//  Sits between the MEM stage / LSU and storage.
// PARAMETERS
//  ADDR_W       32    request address width
//  DEPTH_BYTES  1024  memory size in bytes; multiple of 4, >= 8
//  RD_LAT       1     response latency in cycles after acceptance, 1..4
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       reset, asynchronous, active-high
//  clr_req    in   1       soft-clear request pulse
//  busy       out  1       1 while the clear FSM runs
//  req_valid  in   1       request present
//  req_ready  out  1       request accepted when valid&ready
//  req_we     in   1       1=store, 0=load
//  req_width  in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_sext   in   1       sign-extend loads of byte/half
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   32      store data, right-aligned
//  rsp_valid  out  1       response strobe, one per accepted request
//  rsp_rdata  out  32      load data; 0 for stores and faults
//  rsp_err    out  1       access fault
//  err_sticky out  1       [DMEM_ERR_STICKY_EN] sticky fault flag
//  err_addr   out  ADDR_W  [DMEM_ERR_STICKY_EN] address of first fault
//  err_clr    in   1       [DMEM_ERR_STICKY_EN] clears sticky status
// BEHAVIOUR
//  - Reset: rsp_valid/rsp_rdata/rsp_err=0, req_ready=0, busy=1, state=CLEAR,
//    clr_ptr=0; all response stages flushed. Reset mid-clear restarts at 0.
//  - FSM CLEAR: zero 4 bytes per cycle at clr_ptr, clr_ptr+=4. Takes
//    DEPTH_BYTES/4 cycles. On the last word go to RUN. req_ready=0, busy=1.
//  - FSM RUN: req_ready=1, busy=0. clr_req=1 -> CLEAR next cycle. A request
//    accepted in the same cycle as clr_req is still executed.
//  - Responses: every accepted request gives exactly one rsp_valid pulse RD_LAT
//    cycles later, in order. There is no response backpressure.
//    Responses in flight at a clear still deliver. Load data is sampled at
//    acceptance, before the clear.
//  - Store commits at the accepting posedge. Byte order is big-endian: byte at
//    addr is the MSB. A load accepted the next cycle returns the new data.
//  - Fault: width=11; half with addr[0]!=0; word with addr[1:0]!=0; or
//    addr+size-1 >= DEPTH_BYTES. Result: no memory change, rsp_err=1,
//    rsp_rdata=0.
//  - Loads: byte/half zero-extended, or sign-extended from bit 7/15 when req_sext=1.
//  - Address compare uses the full ADDR_W width. Arithmetic is done at
//    ADDR_W+1 bits, so addr+3 does not wrap to a false in-range result.
// CONFIGURATION
//  DMEM_ERR_STICKY_EN defined:
//    - First fault sets err_sticky and captures err_addr, at acceptance.
//    - Later faults do not overwrite them. err_clr zeroes both; a fault in
//      the same cycle as err_clr wins.
//    - Reset zeroes both.
//  DMEM_ERR_STICKY_EN undefined: err_* ports are absent; only rsp_err is reported.
// STRUCTURE
//  - dmem_pkg: width codes (W_BYTE/W_HALF/W_WORD), state enum {CLEAR,RUN},
//    and the fault-check function.
//  - Sub-module dmem_rsp_pipe: RD_LAT-stage shift register carrying
//    {valid, err, rdata}, async-reset valid bits.
// TESTING  (DEPTH_BYTES=64, RD_LAT=2)
//  1. Release reset -> busy=1, req_ready=0 for 16 cycles. Then ready=1; lw @0x00
//     -> rsp 2 cycles later, rdata=0x00000000, err=0.
//  2. sw 0x80007F01 @0x10. Then lb sext @0x10 -> 0xFFFFFF80; lbu @0x13
//     -> 0x00000001; lh sext @0x12 -> 0x00007F01; lhu @0x10 -> 0x00008000.
//  3. Back-to-back sb 0xAB @0x20 then lbu @0x20 next cycle -> two rsp pulses on
//     consecutive cycles, in order; second rdata=0x000000AB.
//  4. sw @0x12 -> err=1, word @0x10 unchanged. lb @0x40 -> err=1.
//     width=11 -> err=1. With DMEM_ERR_STICKY_EN: err_addr=0x12, stays after
//     later faults.
//  5. Two loads accepted, clr_req in the second's cycle -> both rsp delivered
//     with old data. busy=1 for 16 cycles, then lw @0x10 -> 0.
//  6. Assert reset with a rsp pending and mid-clear -> rsp_valid=0 at once,
//     no pulse after release. Clear restarts: busy for 16 full cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and the access-fault check for the data_mem_hs data memory.
// Width codes, FSM states and the response-stage record live here.
package dmem_pkg;

    typedef enum logic [1:0] {
        W_BYTE    = 2'b00,
        W_HALF    = 2'b01,
        W_WORD    = 2'b10,
        W_ILLEGAL = 2'b11
    } width_e;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    // One extra bit on the end-address sum keeps addr+3 from wrapping into range.
    function automatic logic access_fault(input width_e      width,
                                          input logic [63:0] addr,
                                          input logic [63:0] depth_bytes);
        logic [64:0] last;
        logic        misaligned;
        logic        legal;
        legal      = 1'b1;
        misaligned = 1'b0;
        last       = {1'b0, addr};
        case (width)
            W_BYTE: last = {1'b0, addr};
            W_HALF: begin
                last       = {1'b0, addr} + 65'd1;
                misaligned = addr[0];
            end
            W_WORD: begin
                last       = {1'b0, addr} + 65'd3;
                misaligned = |addr[1:0];
            end
            default: legal = 1'b0;
        endcase
        return !legal || misaligned || (last >= {1'b0, depth_bytes});
    endfunction

endpackage

// File: rtl/data_mem_hs_if.sv
// Request/response channel of the data memory: valid/ready request, fixed-latency response.
interface data_mem_hs_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    width_e            req_width;
    logic              req_sext;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_width, req_sext, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_width, req_sext, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_rsp_pipe.sv
// RD_LAT-deep shift register carrying {valid, err, rdata} from acceptance to the response port.
module dmem_rsp_pipe
    import dmem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  rsp_t rsp_in,
    output rsp_t rsp_out
);

    rsp_t stage [RD_LAT];

    // Reset flushes every stage so nothing in flight survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= rsp_in;
            for (int i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign rsp_out = stage[RD_LAT-1];

endmodule

// File: rtl/data_mem_hs.sv
// Big-endian byte-addressed data memory with hardware clear FSM and fixed-latency responses.
// Optional sticky fault capture is enabled by defining DMEM_ERR_STICKY_EN.
module data_mem_hs
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int RD_LAT      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              busy,
`ifdef DMEM_ERR_STICKY_EN
    output logic              err_sticky,
    output logic [ADDR_W-1:0] err_addr,
    input  logic              err_clr,
`endif
    data_mem_hs_if.slave      bus
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);

    logic [7:0]       mem [DEPTH_BYTES];

    state_e           state;
    state_e           state_next;
    logic [IDX_W-1:0] clr_ptr;
    logic             clr_last;
    logic             req_ready;

    logic             accept;
    logic             fault;
    logic [1:0]       lane;
    logic [IDX_W-1:0] rd_base;
    logic [31:0]      rd_word;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;

    logic [IDX_W-1:0] wr_base;
    logic [3:0]       wr_en;
    logic [0:3][7:0]  wr_bytes;

    rsp_t             rsp_in;
    rsp_t             rsp_out;

    assign clr_last = (clr_ptr == IDX_W'(DEPTH_BYTES - 4));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        case (state)
            CLEAR: begin
                if (clr_last) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (clr_req) begin
                    state_next = CLEAR;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // The pointer parks at zero outside CLEAR so every clear pass starts from word 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_last ? '0 : clr_ptr + IDX_W'(4);
        end else begin
            clr_ptr <= '0;
        end
    end

    assign bus.req_ready = req_ready;
    assign accept        = bus.req_valid && req_ready;
    assign fault         = access_fault(bus.req_width, 64'(bus.req_addr), 64'(DEPTH_BYTES));
    assign lane          = bus.req_addr[1:0];
    assign rd_base       = {bus.req_addr[IDX_W-1:2], 2'b00};
    assign rd_word       = {mem[rd_base], mem[rd_base + IDX_W'(1)],
                            mem[rd_base + IDX_W'(2)], mem[rd_base + IDX_W'(3)]};

    // Lane 0 of the aligned word is the lowest address and therefore the MSB.
    always_comb begin
        ld_byte = 8'h00;
        case (lane)
            2'd0: ld_byte = rd_word[31:24];
            2'd1: ld_byte = rd_word[23:16];
            2'd2: ld_byte = rd_word[15:8];
            2'd3: ld_byte = rd_word[7:0];
            default: ld_byte = 8'h00;
        endcase
        ld_half = lane[1] ? rd_word[15:0] : rd_word[31:16];
        case (bus.req_width)
            W_BYTE:  ld_data = {{24{bus.req_sext & ld_byte[7]}}, ld_byte};
            W_HALF:  ld_data = {{16{bus.req_sext & ld_half[15]}}, ld_half};
            W_WORD:  ld_data = rd_word;
            default: ld_data = 32'h0;
        endcase
    end

    always_comb begin
        wr_base  = rd_base;
        wr_en    = 4'b0000;
        wr_bytes = '0;
        if (state == CLEAR) begin
            wr_base = clr_ptr;
            wr_en   = 4'b1111;
        end else if (accept && bus.req_we && !fault) begin
            case (bus.req_width)
                W_BYTE: begin
                    wr_en[lane]    = 1'b1;
                    wr_bytes[lane] = bus.req_wdata[7:0];
                end
                W_HALF: begin
                    wr_en[{lane[1], 1'b0}]    = 1'b1;
                    wr_en[{lane[1], 1'b1}]    = 1'b1;
                    wr_bytes[{lane[1], 1'b0}] = bus.req_wdata[15:8];
                    wr_bytes[{lane[1], 1'b1}] = bus.req_wdata[7:0];
                end
                W_WORD: begin
                    wr_en    = 4'b1111;
                    wr_bytes = bus.req_wdata;
                end
                default: wr_en = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) begin
                mem[wr_base + IDX_W'(k)] <= wr_bytes[k];
            end
        end
    end

    always_comb begin
        rsp_in       = '0;
        rsp_in.valid = accept;
        rsp_in.err   = accept && fault;
        if (accept && !bus.req_we && !fault) begin
            rsp_in.rdata = ld_data;
        end
    end

    dmem_rsp_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rsp_pipe (
        .clk     (clk),
        .reset   (reset),
        .rsp_in  (rsp_in),
        .rsp_out (rsp_out)
    );

    assign bus.rsp_valid = rsp_out.valid;
    assign bus.rsp_err   = rsp_out.err;
    assign bus.rsp_rdata = rsp_out.rdata;

`ifdef DMEM_ERR_STICKY_EN
    // A fault arriving with err_clr re-arms the capture with its own address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sticky <= 1'b0;
            err_addr   <= '0;
        end else if (accept && fault && (!err_sticky || err_clr)) begin
            err_sticky <= 1'b1;
            err_addr   <= bus.req_addr;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
            err_addr   <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs (DEPTH_BYTES=64, RD_LAT=2); sticky checks follow DMEM_ERR_STICKY_EN.
module tb_data_mem_hs;
    import dmem_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 64;
    localparam int LAT    = 2;

    logic clk;
    logic reset;
    logic clr_req;
    logic busy;
`ifdef DMEM_ERR_STICKY_EN
    logic              err_sticky;
    logic [ADDR_W-1:0] err_addr;
    logic              err_clr;
`endif

    int   total;
    int   bad;
    int   cyc;
    logic saw;

    data_mem_hs_if #(.ADDR_W(ADDR_W)) bus ();

    data_mem_hs #(
        .ADDR_W      (ADDR_W),
        .DEPTH_BYTES (DEPTH),
        .RD_LAT      (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clr_req    (clr_req),
        .busy       (busy),
`ifdef DMEM_ERR_STICKY_EN
        .err_sticky (err_sticky),
        .err_addr   (err_addr),
        .err_clr    (err_clr),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic we, input width_e width, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_width = width;
        bus.req_sext  = sext;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    task automatic idle_bus();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_width = W_BYTE;
        bus.req_sext  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    // Called at a negedge with an idle pipe; returns at the negedge where the response is visible.
    task automatic single(input string tag, input logic we, input width_e width, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        drive(we, width, sext, addr, wdata);
        @(negedge clk);
        idle_bus();
        check({tag, "_early"}, 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
        check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    endtask

    task automatic wait_idle(input int start, output int cycles, output logic saw_rsp);
        cycles  = start;
        saw_rsp = 1'b0;
        while (busy === 1'b1 && cycles < 200) begin
            @(negedge clk);
            cycles++;
            saw_rsp = saw_rsp | bus.rsp_valid;
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        clr_req = 1'b0;
`ifdef DMEM_ERR_STICKY_EN
        err_clr = 1'b0;
`endif
        idle_bus();
        repeat (3) @(negedge clk);

        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
`ifdef DMEM_ERR_STICKY_EN
        check("rst_sticky", 32'(err_sticky), 32'd0);
`endif

        // Step 1: initial clear then a word load of zero.
        reset = 1'b0;
        wait_idle(0, cyc, saw);
        check("t1_clear_cycles", 32'(cyc), 32'd16);
        check("t1_ready", 32'(bus.req_ready), 32'd1);
        single("t1_lw0", 1'b0, W_WORD, 1'b0, 32'h00, 32'h0, 32'h0000_0000, 1'b0);

        // Step 2: big-endian store and sub-word loads.
        single("t2_sw", 1'b1, W_WORD, 1'b0, 32'h10, 32'h8000_7F01, 32'h0, 1'b0);
        single("t2_lw", 1'b0, W_WORD, 1'b0, 32'h10, 32'h0, 32'h8000_7F01, 1'b0);
        single("t2_lb", 1'b0, W_BYTE, 1'b1, 32'h10, 32'h0, 32'hFFFF_FF80, 1'b0);
        single("t2_lbu", 1'b0, W_BYTE, 1'b0, 32'h13, 32'h0, 32'h0000_0001, 1'b0);
        single("t2_lh", 1'b0, W_HALF, 1'b1, 32'h12, 32'h0, 32'h0000_7F01, 1'b0);
        single("t2_lhu", 1'b0, W_HALF, 1'b0, 32'h10, 32'h0, 32'h0000_8000, 1'b0);
        single("t2_lh_neg", 1'b0, W_HALF, 1'b1, 32'h10, 32'h0, 32'hFFFF_8000, 1'b0);

        // Step 3: back-to-back store then load of the same byte.
        drive(1'b1, W_BYTE, 1'b0, 32'h20, 32'h0000_00AB);
        @(negedge clk);
        drive(1'b0, W_BYTE, 1'b0, 32'h20, 32'h0);
        check("t3_early", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        idle_bus();
        check("t3_rsp1_valid", 32'(bus.rsp_valid), 32'd1);
        check("t3_rsp1_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        check("t3_rsp2_valid", 32'(bus.rsp_valid), 32'd1);
        check("t3_rsp2_rdata", bus.rsp_rdata, 32'h0000_00AB);
        @(negedge clk);
        check("t3_drained", 32'(bus.rsp_valid), 32'd0);

        // Step 4: faults and range boundaries.
        single("t4_sw_mis", 1'b1, W_WORD, 1'b0, 32'h12, 32'hDEAD_BEEF, 32'h0, 1'b1);
`ifdef DMEM_ERR_STICKY_EN
        check("t4_sticky", 32'(err_sticky), 32'd1);
        check("t4_err_addr", err_addr, 32'h12);
`endif
        single("t4_lw_keep", 1'b0, W_WORD, 1'b0, 32'h10, 32'h0, 32'h8000_7F01, 1'b0);
        single("t4_lb_oor", 1'b0, W_BYTE, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
        single("t4_illegal", 1'b0, W_ILLEGAL, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1);
        single("t4_lh_mis", 1'b0, W_HALF, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
        single("t4_lw_top", 1'b0, W_WORD, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);
        single("t4_lh_top", 1'b0, W_HALF, 1'b0, 32'h3E, 32'h0, 32'h0, 1'b0);
        single("t4_lw_hiaddr", 1'b0, W_WORD, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);
        single("t4_sb_oor", 1'b1, W_BYTE, 1'b0, 32'h0000_0120, 32'h55, 32'h0, 1'b1);
        single("t4_lbu_alias", 1'b0, W_BYTE, 1'b0, 32'h20, 32'h0, 32'h0000_00AB, 1'b0);
`ifdef DMEM_ERR_STICKY_EN
        check("t4_err_addr_kept", err_addr, 32'h12);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t4_clr_sticky", 32'(err_sticky), 32'd0);
        check("t4_clr_addr", err_addr, 32'h0);
        single("t4_refault", 1'b0, W_BYTE, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
        check("t4_refault_addr", err_addr, 32'h40);
        drive(1'b0, W_BYTE, 1'b0, 32'h41, 32'h0);
        err_clr = 1'b1;
        @(negedge clk);
        idle_bus();
        err_clr = 1'b0;
        check("t4_win_sticky", 32'(err_sticky), 32'd1);
        check("t4_win_addr", err_addr, 32'h41);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
`endif

        // Step 5: clear requested alongside the second of two loads.
        drive(1'b0, W_WORD, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        drive(1'b0, W_BYTE, 1'b0, 32'h20, 32'h0);
        clr_req = 1'b1;
        @(negedge clk);
        idle_bus();
        clr_req = 1'b0;
        check("t5_rsp1_valid", 32'(bus.rsp_valid), 32'd1);
        check("t5_rsp1_rdata", bus.rsp_rdata, 32'h8000_7F01);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("t5_rsp2_valid", 32'(bus.rsp_valid), 32'd1);
        check("t5_rsp2_rdata", bus.rsp_rdata, 32'h0000_00AB);
        wait_idle(1, cyc, saw);
        check("t5_clear_cycles", 32'(cyc), 32'd16);
        single("t5_lw_cleared", 1'b0, W_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
        single("t5_lbu_cleared", 1'b0, W_BYTE, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

        // Step 6: reset with responses in flight during a clear.
        drive(1'b0, W_WORD, 1'b0, 32'h04, 32'h0);
        @(negedge clk);
        drive(1'b0, W_WORD, 1'b0, 32'h08, 32'h0);
        clr_req = 1'b1;
        @(negedge clk);
        idle_bus();
        clr_req = 1'b0;
        check("t6_pre_valid", 32'(bus.rsp_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd1);
        check("t6_rst_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_idle(0, cyc, saw);
        check("t6_clear_cycles", 32'(cyc), 32'd16);
        check("t6_no_ghost_rsp", 32'(saw), 32'd0);
        drive(1'b0, W_BYTE, 1'b0, 32'h00, 32'h0);
        @(negedge clk);
        idle_bus();
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_idle(0, cyc, saw);
        check("t6_restart_cycles", 32'(cyc), 32'd16);
`ifdef DMEM_ERR_STICKY_EN
        check("t6_sticky_after_rst", 32'(err_sticky), 32'd0);
`endif
        single("t6_lw_after", 1'b0, W_WORD, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
